// File: rtl/shift_executor_pkg.sv
// shift_executor_pkg: shared state encodings and default widths for the serial shifter
package shift_executor_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int AMT_W_DEF  = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_executor_counter.sv
// shift_counter: loadable down-counter that flags when one step remains
module shift_counter
    import shift_executor_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic [AMT_W-1:0] loadVal,
    input  logic             dec,
    output logic             isOne
);

    logic [AMT_W-1:0] count;

    // load wins over decrement so a back-to-back start always gets a fresh count
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            count <= '0;
        else if (load)
            count <= loadVal;
        else if (dec)
            count <= count - AMT_W'(1);
    end

    assign isOne = (count == AMT_W'(1));

endmodule

// File: rtl/shift_executor.sv
// shift_executor: serial right shifter, one bit per clock, with start/done handshake
module shift_executor
    import shift_executor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic              arith,
    input  logic [AMT_W-1:0]  shiftAmt,
    input  logic [DATA_W-1:0] dataIn,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dataOut
);

    localparam logic [AMT_W-1:0] FULL = AMT_W'(DATA_W);

    state_t            state;
    state_t            nxt;
    logic [DATA_W-1:0] shreg;
    logic              arith_q;
    logic              is_one;
    logic              accept;
    logic [AMT_W-1:0]  eff;
    logic              fill;

    assign ready   = (state != S_SHIFT);
    assign busy    = (state == S_SHIFT);
    assign done    = (state == S_DONE);
    assign accept  = ready & start;
    assign eff     = ({1'b0, shiftAmt} >= {1'b0, FULL}) ? FULL : shiftAmt;
    assign fill    = arith_q & shreg[DATA_W-1];
    assign dataOut = shreg;

    shift_counter #(.AMT_W(AMT_W)) u_cnt (
        .clk     (clk),
        .rstN    (rstN),
        .load    (accept),
        .loadVal (eff),
        .dec     (busy),
        .isOne   (is_one)
    );

    // state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // next state: shift until the last step, otherwise accept or fall back to idle
    always_comb begin
        nxt = state;
        nxt = (state == S_SHIFT) ? (is_one ? S_DONE : S_SHIFT)
            : accept ? ((eff == '0) ? S_DONE : S_SHIFT)
            : S_IDLE;
    end

    // operand capture on accept, one-bit right shift per SHIFT cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shreg   <= '0;
            arith_q <= 1'b0;
        end else if (accept) begin
            shreg   <= dataIn;
            arith_q <= arith;
        end else if (busy) begin
            shreg   <= {fill, shreg[DATA_W-1:1]};
        end
    end

endmodule

// File: tb/tb_shift_executor.sv
// tb_shift_executor: table, directed and random checks of the serial shifter
module tb_shift_executor;

    logic        clk = 0;
    logic        rstN = 0;
    logic        start = 0;
    logic        arith = 0;
    logic [5:0]  shiftAmt = 0;
    logic [31:0] dataIn = 0;
    logic        ready, busy, done;
    logic [31:0] dataOut;

    int tests = 0;
    int fails = 0;

    shift_executor dut (
        .clk(clk), .rstN(rstN), .start(start), .arith(arith),
        .shiftAmt(shiftAmt), .dataIn(dataIn),
        .ready(ready), .busy(busy), .done(done), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a;
        logic [5:0]  amt;
        logic [31:0] d;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic a, input logic [5:0] amt, input logic [31:0] d);
        int e;
        logic [31:0] r;
        e = (amt > 32) ? 32 : int'(amt);
        r = d;
        for (int i = 0; i < e; i++) r = $unsigned($signed({a & r[31], r}) >>> 1);
        return r;
    endfunction

    function automatic int lat_of(input logic [5:0] amt);
        return (amt > 32) ? 32 : int'(amt);
    endfunction

    // start one operation, wait for done; returns edges after the start edge and busy cycles seen
    task automatic run_op(input logic a, input logic [5:0] amt, input logic [31:0] d,
                          output int lat, output int bcnt, output logic [31:0] res);
        arith = a; shiftAmt = amt; dataIn = d; start = 1;
        @(posedge clk); #1;
        start = 0;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = dataOut;
    endtask

    initial begin
        int lat, bcnt, n;
        logic [31:0] res, r1;
        logic seen;
        vecs[0] = '{0, 6'd4,  32'h8000_00F0, 32'h0800_000F, 4};
        vecs[1] = '{1, 6'd4,  32'h8000_00F0, 32'hF800_000F, 4};
        vecs[2] = '{0, 6'd0,  32'h1234_5678, 32'h1234_5678, 0};
        vecs[3] = '{0, 6'd2,  32'hA5A5_A5A4, 32'h2969_6969, 2};
        vecs[4] = '{0, 6'd63, 32'hFFFF_FFFF, 32'h0000_0000, 32};
        vecs[5] = '{1, 6'd63, 32'h8000_0000, 32'hFFFF_FFFF, 32};
        vecs[6] = '{1, 6'd32, 32'h7FFF_FFFF, 32'h0000_0000, 32};
        vecs[7] = '{1, 6'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31};
        vecs[8] = '{0, 6'd1,  32'h0000_0001, 32'h0000_0000, 1};

        #12;
        check("reset_dataOut", dataOut, 0);
        check("reset_flags", {29'd0, ready, busy, done}, 32'd4);
        @(negedge clk); rstN = 1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].amt, vecs[i].d, lat, bcnt, res);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp_d);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy", i), bcnt, vecs[i].exp_lat);
            check($sformatf("vec%0d_ready", i), {31'd0, ready}, 1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", i), {31'd0, done}, 0);
        end

        arith = 0; shiftAmt = 6'd20; dataIn = 32'hFFFF_0000; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (4) @(posedge clk);
        #3 rstN = 0; #1;
        check("midreset_dataOut", dataOut, 0);
        check("midreset_flags", {29'd0, ready, busy, done}, 32'd4);
        @(negedge clk); rstN = 1;
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (done) seen = 1; end
        check("midreset_nodone", {31'd0, seen}, 0);

        arith = 1; shiftAmt = 6'd10; dataIn = 32'h9ABC_DEF0; start = 1;
        @(posedge clk); #1; start = 0;
        arith = 0; shiftAmt = 6'd1; dataIn = 32'h0; 
        repeat (2) @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1; start = 0;
        n = 3;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("ignore_lat", n, 10);
        check("ignore_data", dataOut, model(1, 6'd10, 32'h9ABC_DEF0));
        @(posedge clk); #1;

        arith = 0; shiftAmt = 6'd3; dataIn = 32'hF0F0_F0F0; start = 1;
        @(posedge clk); #1;
        arith = 1; shiftAmt = 6'd2; dataIn = 32'h8000_0010;
        n = 0;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("b2b_first_lat", n, 3);
        r1 = dataOut;
        check("b2b_first_data", r1, 32'h1E1E_1E1E);
        @(posedge clk); #1;
        start = 0;
        check("b2b_no_idle", {30'd0, busy, ready}, 32'd2);
        n = 1;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("b2b_gap", n, 3);
        check("b2b_second_data", dataOut, 32'hE000_0004);
        @(posedge clk); #1;

        for (int k = 0; k < 150; k++) begin
            logic        a;
            logic [5:0]  amt;
            logic [31:0] d;
            a = 1'($urandom);
            amt = 6'($urandom_range(0, 63));
            d = $urandom;
            run_op(a, amt, d, lat, bcnt, res);
            check($sformatf("rand%0d_data", k), res, model(a, amt, d));
            check($sformatf("rand%0d_lat", k), lat, lat_of(amt));
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
